// File: rtl/i2c_master_buffer_if.sv
// Byte-level handshake between the transaction buffer and an I2C master core.
interface i2c_master_buffer_if #(
    parameter int unsigned LW = 5
) ();
    logic          m_start;
    logic          m_rnw;
    logic [LW-1:0] m_size;
    logic [6:0]    m_addr;
    logic [7:0]    m_data_o;
    logic          m_busy;
    logic          m_dataReq;
    logic          m_newData;
    logic [7:0]    m_data_i;

    modport master (
        output m_start, m_rnw, m_size, m_addr, m_data_o,
        input  m_busy, m_dataReq, m_newData, m_data_i
    );

    modport slave (
        input  m_start, m_rnw, m_size, m_addr, m_data_o,
        output m_busy, m_dataReq, m_newData, m_data_i
    );
endinterface

// File: rtl/i2c_master_buffer.sv
// TX/RX byte buffers plus a transaction sequencer that drives an I2C master core.
// Bytes are queued while idle, streamed to/from the core, and consumed TX bytes are compacted.
module i2c_master_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LW      = 5,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [6:0]  ADDR    = 7'h40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          read_nwrite,
    input  logic [LW-1:0] len,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic [LW-1:0] rd_idx,
    output logic [7:0]    rd_data,
    output logic [LW-1:0] rx_count,
    output logic [LW-1:0] tx_count,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic          err_len,
    output logic          overflow,
    i2c_master_buffer_if.master m
);

    localparam int unsigned   IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        ACTIVE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    tx_buf_q [DEPTH];
    logic [7:0]    tx_buf_d [DEPTH];
    logic [7:0]    rx_buf_q [DEPTH];
    logic [7:0]    rx_buf_d [DEPTH];
    logic [LW-1:0] tx_count_q, tx_count_d;
    logic [LW-1:0] rx_count_q, rx_count_d;
    logic [LW-1:0] tx_rptr_q, tx_rptr_d;
    logic [LW-1:0] m_size_q, m_size_d;
    logic          m_rnw_q, m_rnw_d;
    logic          m_start_q, m_start_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_len_q, err_len_d;
    logic          overflow_q, overflow_d;
    logic          m_busy_q, m_busy_d;
    logic          data_req_q, data_req_d;
    logic          new_data_q, new_data_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          data_req_rise;
    logic          new_data_rise;

    // Next-state, buffer and flag update logic.
    always_comb begin
        state_d       = state_q;
        tx_buf_d      = tx_buf_q;
        rx_buf_d      = rx_buf_q;
        tx_count_d    = tx_count_q;
        rx_count_d    = rx_count_q;
        tx_rptr_d     = tx_rptr_q;
        m_size_d      = m_size_q;
        m_rnw_d       = m_rnw_q;
        m_start_d     = 1'b0;
        done_d        = 1'b0;
        err_timeout_d = err_timeout_q;
        err_len_d     = err_len_q;
        overflow_d    = overflow_q;
        timer_d       = timer_q;
        m_busy_d      = m.m_busy;
        data_req_d    = m.m_dataReq;
        new_data_d    = m.m_newData;
        data_req_rise = m.m_dataReq & ~data_req_q;
        new_data_rise = m.m_newData & ~new_data_q;

        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    tx_count_d    = '0;
                    rx_count_d    = '0;
                    tx_rptr_d     = '0;
                    err_timeout_d = 1'b0;
                    err_len_d     = 1'b0;
                    overflow_d    = 1'b0;
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        tx_buf_d[IW'(i)] = '0;
                        rx_buf_d[IW'(i)] = '0;
                    end
                end else begin
                    // The push lands first so a same-cycle go sees the new count.
                    if (wr_en) begin
                        if (tx_count_q == DEPTH_L) begin
                            overflow_d = 1'b1;
                        end else begin
                            tx_buf_d[IW'(tx_count_q)] = wr_data;
                            tx_count_d                = tx_count_q + LW'(1);
                        end
                    end
                    if (go) begin
                        if (len == '0 || len > DEPTH_L || (!read_nwrite && len > tx_count_d)) begin
                            err_len_d = 1'b1;
                        end else begin
                            m_rnw_d   = read_nwrite;
                            m_size_d  = len;
                            tx_rptr_d = '0;
                            if (read_nwrite) begin
                                rx_count_d = '0;
                            end
                            m_start_d = 1'b1;
                            state_d   = START;
                        end
                    end
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (m.m_busy) begin
                    state_d = ACTIVE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ACTIVE: begin
                if (!m_rnw_q) begin
                    if (data_req_rise && tx_rptr_q < m_size_q) begin
                        tx_rptr_d = tx_rptr_q + LW'(1);
                    end
                end else if (new_data_rise) begin
                    if (rx_count_q == DEPTH_L) begin
                        overflow_d = 1'b1;
                    end else begin
                        rx_buf_d[IW'(rx_count_q)] = m.m_data_i;
                        rx_count_d                = rx_count_q + LW'(1);
                    end
                end
                if (!m_busy_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Drop the bytes the core consumed and slide the rest down to index 0.
                if (!m_rnw_q) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        if (i + int'(tx_rptr_q) < int'(DEPTH)) begin
                            tx_buf_d[IW'(i)] = tx_buf_q[IW'(i + int'(tx_rptr_q))];
                        end else begin
                            tx_buf_d[IW'(i)] = '0;
                        end
                    end
                    tx_count_d = tx_count_q - tx_rptr_q;
                    tx_rptr_d  = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tx_count_q    <= '0;
            rx_count_q    <= '0;
            tx_rptr_q     <= '0;
            m_size_q      <= '0;
            m_rnw_q       <= 1'b0;
            m_start_q     <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_len_q     <= 1'b0;
            overflow_q    <= 1'b0;
            m_busy_q      <= 1'b0;
            data_req_q    <= 1'b0;
            new_data_q    <= 1'b0;
            timer_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tx_buf_q[IW'(i)] <= '0;
                rx_buf_q[IW'(i)] <= '0;
            end
        end else begin
            state_q       <= state_d;
            tx_buf_q      <= tx_buf_d;
            rx_buf_q      <= rx_buf_d;
            tx_count_q    <= tx_count_d;
            rx_count_q    <= rx_count_d;
            tx_rptr_q     <= tx_rptr_d;
            m_size_q      <= m_size_d;
            m_rnw_q       <= m_rnw_d;
            m_start_q     <= m_start_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
            err_len_q     <= err_len_d;
            overflow_q    <= overflow_d;
            m_busy_q      <= m_busy_d;
            data_req_q    <= data_req_d;
            new_data_q    <= new_data_d;
            timer_q       <= timer_d;
        end
    end

    assign rd_data     = (rd_idx < DEPTH_L) ? rx_buf_q[IW'(rd_idx)] : 8'h00;
    assign rx_count    = rx_count_q;
    assign tx_count    = tx_count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
    assign err_len     = err_len_q;
    assign overflow    = overflow_q;

    assign m.m_start   = m_start_q;
    assign m.m_rnw     = m_rnw_q;
    assign m.m_size    = m_size_q;
    assign m.m_addr    = ADDR;
    assign m.m_data_o  = (tx_rptr_q < DEPTH_L) ? tx_buf_q[IW'(tx_rptr_q)] : 8'h00;

endmodule
